cordic_sched: RTL

//  Sequencer for the NF-bin CORDIC coefficient engine of the Goertzel bank.

---
 rtl/cordic_sched.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cordic_sched.sv
// Coefficient-bank sequencer for the Goertzel CORDIC engine: computes per-bin angles
// serially, resets and runs the CORDIC, then latches cos/sin/alpha into a stable bank.
module cordic_sched #(
   parameter int NF      = 11,
   parameter int KW      = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [$clog2(NF)-1:0] cfg_addr,
   input  logic [KW-1:0]         cfg_k,
   input  logic                  step_we,
   input  logic [31:0]           step_i,
   input  logic                  start,
   output logic                  busy,
   output logic                  coef_valid,
   output logic [1:0]            err,
   output logic                  cordic_rstn,
   output logic                  cordic_en,
   input  logic                  cordic_ready,
   output logic [NF*32-1:0]      cordic_ang,
   input  logic [NF*32-1:0]      cordic_cos,
   input  logic [NF*32-1:0]      cordic_sin,
   input  logic [NF*32-1:0]      cordic_alpha,
   output logic [NF*32-1:0]      coef_cos,
   output logic [NF*32-1:0]      coef_sin,
   output logic [NF*32-1:0]      coef_alpha
);

   localparam int AW = $clog2(NF);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [31:0] PI_FX = 32'h0324_3F6A;

   typedef enum logic [2:0] {IDLE, CALC, CRST, RUN, CAPT} state_t;

   state_t            state_reg, state_next;
   logic [KW-1:0]     k_reg [NF];
   logic [31:0]       ang_reg [NF];
   logic [31:0]       step_reg;
   logic [AW-1:0]     i_reg;
   logic [CW-1:0]     cnt_reg;
   logic              busy_reg, coef_valid_reg, cordic_en_reg, cordic_rstn_reg;
   logic [1:0]        err_reg;
   logic [NF*32-1:0]  coef_cos_reg, coef_sin_reg, coef_alpha_reg;

   logic [KW-1:0]        k_cur;
   logic signed [KW+32:0] k_ext, step_ext, prod;
   logic                 range_bad, last_bin, timed_out, cfg_ok, step_ok;

   // k is unsigned, so it is zero-extended before the signed multiply
   assign k_cur     = k_reg[i_reg];
   assign k_ext     = {33'b0, k_cur};
   assign step_ext  = {{(KW+1){step_reg[31]}}, step_reg};
   assign prod      = k_ext * step_ext;
   assign range_bad = (prod[KW+32:32] != '0) || (prod[31:0] > PI_FX);
   assign last_bin  = (i_reg == AW'(NF - 1));
   assign timed_out = (cnt_reg == CW'(TIMEOUT - 1));
   assign cfg_ok    = cfg_we && (state_reg == IDLE) && ({1'b0, cfg_addr} < (AW+1)'(NF));
   assign step_ok   = step_we && (state_reg == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: if (start) state_next = CALC;
         CALC: begin
            if (range_bad)     state_next = IDLE;
            else if (last_bin) state_next = CRST;
         end
         CRST: if (cnt_reg == CW'(1)) state_next = RUN;
         RUN: begin
            if (cordic_ready)   state_next = CAPT;
            else if (timed_out) state_next = IDLE;
         end
         CAPT:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // CORDIC controls are registered from the next state so they change cleanly with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cordic_en_reg   <= 1'b0;
         cordic_rstn_reg <= 1'b0;
         cnt_reg         <= '0;
      end else begin
         cordic_en_reg   <= (state_next == RUN);
         cordic_rstn_reg <= (state_next != CRST);
         if ((state_next == state_reg) && (state_reg == CRST || state_reg == RUN))
            cnt_reg <= cnt_reg + CW'(1);
         else
            cnt_reg <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NF; n++) k_reg[n] <= '0;
         step_reg <= '0;
      end else begin
         for (int n = 0; n < NF; n++)
            if (cfg_ok && cfg_addr == AW'(n)) k_reg[n] <= cfg_k;
         if (step_ok) step_reg <= step_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NF; n++) ang_reg[n] <= '0;
         i_reg          <= '0;
         busy_reg       <= 1'b0;
         coef_valid_reg <= 1'b0;
         err_reg        <= 2'b00;
         coef_cos_reg   <= '0;
         coef_sin_reg   <= '0;
         coef_alpha_reg <= '0;
      end else begin
         unique case (state_reg)
            IDLE: if (start) begin
               busy_reg       <= 1'b1;
               coef_valid_reg <= 1'b0;
               err_reg        <= 2'b00;
               i_reg          <= '0;
            end
            CALC: begin
               if (range_bad) begin
                  err_reg[0] <= 1'b1;
                  busy_reg   <= 1'b0;
               end else begin
                  ang_reg[i_reg] <= prod[31:0];
                  i_reg          <= i_reg + AW'(1);
               end
            end
            RUN: if (!cordic_ready && timed_out) begin
               err_reg[1] <= 1'b1;
               busy_reg   <= 1'b0;
            end
            CAPT: begin
               coef_cos_reg   <= cordic_cos;
               coef_sin_reg   <= cordic_sin;
               coef_alpha_reg <= cordic_alpha;
               coef_valid_reg <= 1'b1;
               busy_reg       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NF; gi++) begin : g_ang
         assign cordic_ang[gi*32 +: 32] = ang_reg[gi];
      end
   endgenerate

   assign busy        = busy_reg;
   assign coef_valid  = coef_valid_reg;
   assign err         = err_reg;
   assign cordic_en   = cordic_en_reg;
   assign cordic_rstn = cordic_rstn_reg;
   assign coef_cos    = coef_cos_reg;
   assign coef_sin    = coef_sin_reg;
   assign coef_alpha  = coef_alpha_reg;

endmodule
